// File: rtl/uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx : 8N1 serial receiver with a one-cycle valid / frame-error strobe |
// | Optional: `define UART_RX_MAJORITY_EN for 2-of-3 majority sampling       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_rx #(
   parameter int CLK_PARAM = 50000000,
   parameter int BAUD_RATE = 9600
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   output logic [7:0] DATA_OUT,
   output logic       DATA_VALID,
   output logic       FRAME_ERR,
   output logic       BUSY
);
   localparam int BAUD_CLK = CLK_PARAM / BAUD_RATE;
   localparam int HALF_CLK = BAUD_CLK / 2;
   localparam int CNT_W    = (BAUD_CLK > 1) ? $clog2(BAUD_CLK) : 1;
   localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(BAUD_CLK - 1);
   localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_CLK - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
      S_STOP  = 3'd3,
      S_BREAK = 3'd4
   } state_t;

   state_t           state, state_nxt;
   logic             sync_1, rx_s;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       bit_idx, bit_idx_nxt;
   logic [7:0]       shift, shift_nxt, data_nxt;
   logic             valid_nxt, ferr_nxt;
   logic             at_target, sample;

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_1 <= 1'b1;
         rx_s   <= 1'b1;
      end else begin
         sync_1 <= RX_IN;
         rx_s   <= sync_1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Two previous rx_s values plus the current one form the 3-sample window.
   logic [1:0] hist;

   always_ff @(posedge CLK) begin
      if (RST) hist <= 2'b11;
      else     hist <= {hist[0], rx_s};
   end

   assign sample = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
   assign sample = rx_s;
`endif

   assign at_target = (state == S_START) ? (cnt == HALF_END) : (cnt == BIT_END);
   assign BUSY      = (state != S_IDLE);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         cnt        <= '0;
         bit_idx    <= 3'd0;
         shift      <= 8'h00;
         DATA_OUT   <= 8'h00;
         DATA_VALID <= 1'b0;
         FRAME_ERR  <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         bit_idx    <= bit_idx_nxt;
         shift      <= shift_nxt;
         DATA_OUT   <= data_nxt;
         DATA_VALID <= valid_nxt;
         FRAME_ERR  <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt + CNT_W'(1);
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      data_nxt    = DATA_OUT;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            if (!rx_s) state_nxt = S_START;
         end
         S_START: begin
            if (at_target) begin
               cnt_nxt = '0;
               if (!sample) begin
                  state_nxt   = S_DATA;
                  bit_idx_nxt = 3'd0;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (at_target) begin
               cnt_nxt            = '0;
               shift_nxt[bit_idx] = sample;
               if (bit_idx == 3'd7) state_nxt   = S_STOP;
               else                 bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            // Leaving at mid-stop-bit lets a directly following start bit be seen.
            if (at_target) begin
               cnt_nxt = '0;
               if (sample) begin
                  data_nxt  = shift;
                  valid_nxt = 1'b1;
                  state_nxt = S_IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = S_BREAK;
               end
            end
         end
         S_BREAK: begin
            cnt_nxt = '0;
            if (rx_s) state_nxt = S_IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = S_IDLE;
         end
      endcase
   end
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx : scoreboard bench for uart_rx at BAUD_CLK=16, HALF_CLK=8      |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_rx;
   localparam int LAT_NOM = 2 + 1 + 8 + 9 * 16;

   typedef struct {
      logic [7:0] data;
      int         start;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_in = 1'b1;
   logic [7:0] data_out;
   logic       data_valid, frame_err, busy;

   int   tests_run = 0;
   int   fails = 0;
   int   cyc = 0;
   int   valid_count = 0;
   int   ferr_count = 0;
   logic prev_valid = 1'b0;
   exp_t sb[$];
   exp_t m_e;
   int   m_lat;

   uart_rx #(.CLK_PARAM(1600), .BAUD_RATE(100)) dut (
      .CLK(clk), .RST(rst), .RX_IN(rx_in), .DATA_OUT(data_out),
      .DATA_VALID(data_valid), .FRAME_ERR(frame_err), .BUSY(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: pops the scoreboard on every valid strobe.
   always @(negedge clk) begin
      if (!rst) begin
         if (data_valid === 1'b1) begin
            valid_count++;
            tests_run++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL unexpected_valid: DATA_OUT=%h, required no strobe", data_out);
            end else begin
               m_e = sb.pop_front();
               if (data_out !== m_e.data) begin
                  fails++;
                  $display("FAIL rx_data: got %h, required %h", data_out, m_e.data);
               end
               tests_run++;
               m_lat = cyc - m_e.start;
               if (m_lat < LAT_NOM - 1 || m_lat > LAT_NOM + 1) begin
                  fails++;
                  $display("FAIL latency: got %0d cycles, required %0d+/-1", m_lat, LAT_NOM);
               end
            end
         end
         if (prev_valid) begin
            tests_run++;
            if (data_valid !== 1'b0) begin
               fails++;
               $display("FAIL valid_width: DATA_VALID=%b after pulse, required 0", data_valid);
            end
         end
         if (data_valid === 1'b1 || frame_err === 1'b1) begin
            tests_run++;
            if (data_valid === 1'b1 && frame_err === 1'b1) begin
               fails++;
               $display("FAIL strobe_overlap: DATA_VALID=1 FRAME_ERR=1, required not both");
            end
         end
         if (frame_err === 1'b1) ferr_count++;
         prev_valid = data_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_b, input int glitch_bit,
                             input logic push, input logic [7:0] exp_d);
      exp_t e;
      if (push) begin
         e.data  = exp_d;
         e.start = cyc;
         sb.push_back(e);
      end
      rx_in = 1'b0;
      repeat (16) tick();
      for (int b = 0; b < 8; b++) begin
         rx_in = d[b];
         if (b == glitch_bit) begin
            repeat (8) tick();
            rx_in = ~d[b];
            tick();
            rx_in = d[b];
            repeat (7) tick();
         end else begin
            repeat (16) tick();
         end
      end
      rx_in = stop_b;
      repeat (16) tick();
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      tests_run++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain_timeout: %0d frames outstanding, required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_byte(input string name, input logic [7:0] exp_d);
      tests_run++;
      if (data_out !== exp_d) begin
         fails++;
         $display("FAIL %s: DATA_OUT=%h, required %h", name, data_out, exp_d);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_in = 1'b1;
      repeat (3) tick();
      check_byte("reset_data", 8'h00);
      tests_run++;
      if ({data_valid, frame_err, busy} !== 3'b000) begin
         fails++;
         $display("FAIL reset_flags: {valid,ferr,busy}=%b, required 000", {data_valid, frame_err, busy});
      end
      rst = 1'b0;
      repeat (4) tick();
   endtask

   task automatic test_single_frame();
      int f0 = ferr_count;
      send_frame(8'hA5, 1'b1, -1, 1'b1, 8'hA5);
      wait_drain();
      repeat (4) tick();
      check_byte("single_data", 8'hA5);
      tests_run++;
      if (busy !== 1'b0 || ferr_count != f0) begin
         fails++;
         $display("FAIL single_idle: BUSY=%b ferr_pulses=%0d, required 0 and 0", busy, ferr_count - f0);
      end
   endtask

   task automatic test_back_to_back();
      int v0 = valid_count;
      send_frame(8'h00, 1'b1, -1, 1'b1, 8'h00);
      send_frame(8'hFF, 1'b1, -1, 1'b1, 8'hFF);
      wait_drain();
      repeat (4) tick();
      tests_run++;
      if (valid_count - v0 != 2) begin
         fails++;
         $display("FAIL b2b_count: got %0d pulses, required 2", valid_count - v0);
      end
      check_byte("b2b_data", 8'hFF);
   endtask

   task automatic test_false_start();
      int v0 = valid_count;
      int f0 = ferr_count;
      rx_in = 1'b0;
      repeat (4) tick();
      rx_in = 1'b1;
      tick();
      tests_run++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL false_start_busy: BUSY=%b during start check, required 1", busy);
      end
      repeat (7) tick();
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL false_start_idle: BUSY=%b at cycle 12, required 0", busy);
      end
      repeat (200) tick();
      tests_run++;
      if (valid_count != v0 || ferr_count != f0) begin
         fails++;
         $display("FAIL false_start_strobe: valid=%0d ferr=%0d, required 0 and 0",
                  valid_count - v0, ferr_count - f0);
      end
   endtask

   task automatic test_frame_error();
      int v0 = valid_count;
      int f0 = ferr_count;
      send_frame(8'h3C, 1'b0, -1, 1'b0, 8'h00);
      repeat (60) tick();
      rx_in = 1'b1;
      repeat (20) tick();
      tests_run++;
      if (ferr_count - f0 != 1 || valid_count != v0) begin
         fails++;
         $display("FAIL frame_err_pulses: ferr=%0d valid=%0d, required 1 and 0",
                  ferr_count - f0, valid_count - v0);
      end
      check_byte("frame_err_hold", 8'hFF);
      tests_run++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL frame_err_busy: BUSY=%b after break, required 0", busy);
      end
      send_frame(8'h12, 1'b1, -1, 1'b1, 8'h12);
      wait_drain();
      repeat (4) tick();
      check_byte("after_err_data", 8'h12);
   endtask

   task automatic test_reset_abort();
      int v0 = valid_count;
      int f0 = ferr_count;
      logic [7:0] d = 8'h0F;
      rx_in = 1'b0;
      repeat (16) tick();
      for (int b = 0; b < 4; b++) begin
         rx_in = d[b];
         repeat (16) tick();
      end
      rst = 1'b1;
      rx_in = 1'b1;
      tick();
      rst = 1'b0;
      check_byte("abort_data", 8'h00);
      tests_run++;
      if ({data_valid, frame_err, busy} !== 3'b000) begin
         fails++;
         $display("FAIL abort_flags: {valid,ferr,busy}=%b, required 000", {data_valid, frame_err, busy});
      end
      repeat (32) tick();
      tests_run++;
      if (valid_count != v0 || ferr_count != f0) begin
         fails++;
         $display("FAIL abort_strobe: valid=%0d ferr=%0d, required 0 and 0",
                  valid_count - v0, ferr_count - f0);
      end
      send_frame(8'h5A, 1'b1, -1, 1'b1, 8'h5A);
      wait_drain();
      repeat (4) tick();
      check_byte("abort_next_data", 8'h5A);
   endtask

   task automatic test_glitch();
      logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
      exp_d = 8'h00;
`else
      exp_d = 8'h04;
`endif
      send_frame(8'h00, 1'b1, 2, 1'b1, exp_d);
      wait_drain();
      repeat (4) tick();
      check_byte("glitch_data", exp_d);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_false_start();
      test_frame_error();
      test_reset_abort();
      test_glitch();
      repeat (10) tick();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive-side partner of the existing transmitter: recovers 8N1 serial frames (1 start, 8 data LSB-first, 1 stop, no parity) from an asynchronous line.
- Presents each received byte on a parallel port with a one-cycle valid strobe.
- Uses the same fixed-clock/baud parameterisation as the transmitter, so a TX output can loop straight into this block's input.

Parameters:
- CLK_PARAM, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bits/s.
- BAUD_CLK (localparam), CLK_PARAM/BAUD_RATE (5208 at defaults), clock cycles per bit.
- HALF_CLK (localparam), BAUD_CLK/2, cycles from start edge to mid-start-bit.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- RX_IN  input  1  asynchronous serial line; idle high.
- DATA_OUT  output  8  last good received byte; held until next good frame.
- DATA_VALID  output  1  one-cycle pulse when DATA_OUT updates.
- FRAME_ERR  output  1  one-cycle pulse when stop bit samples 0.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (RST high at a clock edge):
  - DATA_OUT=8'h00, DATA_VALID=0, FRAME_ERR=0, BUSY=0.
  - Synchroniser flops=1, state=IDLE, counter=0, bit index=0.
  - Reset mid-frame aborts the frame; no strobe is emitted.
- Synchroniser: two-flop chain on RX_IN producing rx_s. The FSM uses only rx_s, adding 2 cycles of latency.
- Counter: width clog2(BAUD_CLK); cleared on every state change. Bit index: 3 bits.
- IDLE: rx_s==0 -> START.
- START:
  - Count to HALF_CLK-1, then sample.
  - Sample 0 -> DATA, bit index=0.
  - Sample 1 (glitch) -> IDLE, no strobe.
- DATA:
  - Count to BAUD_CLK-1, then sample into shift[bit index] (LSB first).
  - Bit index 7 sampled -> STOP; otherwise increment bit index.
- STOP:
  - Count to BAUD_CLK-1, then sample.
  - Sample 1: DATA_OUT<=shift, DATA_VALID=1 for exactly the next cycle, -> IDLE.
  - Sample 0: FRAME_ERR=1 for exactly the next cycle, DATA_OUT unchanged, -> BREAK.
- BREAK: stay until rx_s==1, then -> IDLE. A held-low line never yields extra frames.
- Back-to-back frames: return to IDLE occurs at mid-stop-bit, so a start bit immediately following the stop bit is detected.
- Latency: RX_IN start falling edge to DATA_VALID = 2 + 1 + HALF_CLK + 9*BAUD_CLK cycles, +/-1. The bench checks within that window.
- DATA_VALID and FRAME_ERR are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Keep a 3-deep history of rx_s.
  - Every sample point (start, data, stop) uses the 2-of-3 majority of rx_s at counter values target-2, target-1 and target.
  - A single-cycle glitch at any sample point is rejected.
- Undefined: each sample is rx_s at counter==target only; no history register.
- Timing, ports and strobes are identical either way.

Test Plan (CLK_PARAM=1600, BAUD_RATE=100 -> BAUD_CLK=16, HALF_CLK=8):
- Drive frame 0xA5 on RX_IN -> DATA_OUT=0xA5, DATA_VALID high exactly 1 cycle within latency window, FRAME_ERR stays 0, BUSY low afterwards.
- Frames 0x00 then 0xFF with no idle between (next start directly follows stop bit) -> two DATA_VALID pulses, DATA_OUT=0x00 then 0xFF.
- RX_IN low for 4 cycles, then high -> no DATA_VALID or FRAME_ERR; BUSY returns low by cycle 2+1+8+1.
- Frame 0x3C with stop bit 0, then line held low 60 cycles, then high -> one FRAME_ERR pulse, DATA_OUT keeps previous value, no DATA_VALID, no further strobes; next frame 0x12 received normally.
- Assert RST for 1 cycle after data bit 3 of a frame -> all outputs at reset values next cycle, no strobe. Line idles 32 cycles, then frame 0x5A -> DATA_OUT=0x5A.
- Frame 0x00 with a 1-cycle high glitch on RX_IN timed to land at the data bit 2 sample point -> with UART_RX_MAJORITY_EN: DATA_OUT=0x00; without: DATA_OUT=0x04.
